// File: rtl/bsg_clk_mon_multi.sv
// Purpose : multi-channel slow-clock frequency monitor; counts synchronised rising edges per window.
// Latency : a div_clk_i rise shows up as an edge sync_stages_p+1 cycles later; results land one cycle after the last window cycle.
// Backpressure: none; start_i is only honoured in IDLE, and results are overwritten at every window end.
//
// Ports:
//   clk_i, reset_i     reference clock and synchronous active-high reset
//   start_i            begin a measurement (ignored while busy)
//   continuous_i       1 = start the next window with no gap; checked at every window end
//   window_i           window length in clk_i cycles, latched at start (0 behaves as 1)
//   min_i, max_i       inclusive in-range bounds, sampled at each window end
//   div_clk_i          monitored clocks, asynchronous to clk_i
//   busy_o             high while measuring
//   done_o             one-cycle pulse when the result outputs update
//   count_o            per-channel edge counts of the last completed window
//   in_range_o         per-channel min_i <= count <= max_i (and no saturation)
//   overflow_o         per-channel counter saturated during the last window

module bsg_clk_mon_multi #(
  parameter int els_p          = 4,
  parameter int count_width_p  = 16,
  parameter int window_width_p = 20,
  parameter int sync_stages_p  = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic                             continuous_i,
  input  logic [window_width_p-1:0]        window_i,
  input  logic [count_width_p-1:0]         min_i,
  input  logic [count_width_p-1:0]         max_i,
  input  logic [els_p-1:0]                 div_clk_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [els_p*count_width_p-1:0]   count_o,
  output logic [els_p-1:0]                 in_range_o,
  output logic [els_p-1:0]                 overflow_o
);

  // Fewer than two flops would not give metastability a full cycle to resolve.
  localparam int stages_lp = (sync_stages_p < 2) ? 2 : sync_stages_p;

  localparam logic [window_width_p-1:0] win_one_lp = window_width_p'(1);
  localparam logic [count_width_p-1:0]  cnt_one_lp = count_width_p'(1);

  typedef enum logic {
    e_idle,
    e_measure
  } state_e;

  state_e state_q, state_d;

  // ------------------------------------------------------------------
  // Synchroniser and rising-edge detector
  // ------------------------------------------------------------------
  logic [stages_lp-1:0][els_p-1:0] sync_q;
  logic [els_p-1:0]                hist_q;
  logic [els_p-1:0]                edge_s;

  // The history flop is never cleared between windows, so an edge that
  // arrives right at a window boundary is counted in exactly one window.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= div_clk_i;
      for (int s = 1; s < stages_lp; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[stages_lp-1];
    end
  end

  assign edge_s = sync_q[stages_lp-1] & ~hist_q;

  // ------------------------------------------------------------------
  // Working state
  // ------------------------------------------------------------------
  // rem_q counts down the remaining counting cycles; zero marks the last one.
  logic [window_width_p-1:0] rem_q, rem_d;
  logic [window_width_p-1:0] len_m1_q, len_m1_d;

  logic [els_p-1:0][count_width_p-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [els_p-1:0]                    ovf_q, ovf_d, ovf_nxt;

  // Result registers, held between window ends.
  logic [els_p-1:0][count_width_p-1:0] res_cnt_q, res_cnt_d;
  logic [els_p-1:0]                    res_ovf_q, res_ovf_d;
  logic [els_p-1:0]                    res_inr_q, res_inr_d;
  logic                                done_q, done_d;

  // Saturating per-channel increment. Overflow is flagged when an edge
  // arrives while the counter is already pinned at all-ones.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    for (int i = 0; i < els_p; i++) begin
      if (edge_s[i]) begin
        if (&cnt_q[i]) begin
          ovf_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_q[i] + cnt_one_lp;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Control FSM: next state, working updates and result capture
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_m1_d  = len_m1_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    res_inr_d = res_inr_q;
    done_d    = 1'b0;
    busy_o    = 1'b0;

    case (state_q)
      e_idle: begin
        if (start_i) begin
          // A zero-length window is stretched to one counting cycle.
          len_m1_d = (window_i == '0) ? '0 : (window_i - win_one_lp);
          rem_d    = (window_i == '0) ? '0 : (window_i - win_one_lp);
          cnt_d    = '0;
          ovf_d    = '0;
          state_d  = e_measure;
        end
      end

      e_measure: begin
        busy_o = 1'b1;
        cnt_d  = cnt_nxt;
        ovf_d  = ovf_nxt;
        if (rem_q == '0) begin
          // Last counting cycle: publish including this cycle's edge.
          res_cnt_d = cnt_nxt;
          res_ovf_d = ovf_nxt;
          for (int i = 0; i < els_p; i++) begin
            res_inr_d[i] = !ovf_nxt[i] && (cnt_nxt[i] >= min_i) && (cnt_nxt[i] <= max_i);
          end
          done_d = 1'b1;
          // continuous_i is looked at live here so software can stop a
          // free-running measurement by dropping it mid-window.
          if (continuous_i) begin
            cnt_d = '0;
            ovf_d = '0;
            rem_d = len_m1_q;
          end else begin
            state_d = e_idle;
          end
        end else begin
          rem_d = rem_q - win_one_lp;
        end
      end

      default: begin
        state_d = e_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      rem_q     <= '0;
      len_m1_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= '0;
      res_inr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_m1_q  <= len_m1_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
      res_inr_q <= res_inr_d;
      done_q    <= done_d;
    end
  end

  assign done_o     = done_q;
  assign count_o    = res_cnt_q;
  assign in_range_o = res_inr_q;
  assign overflow_o = res_ovf_q;

endmodule

// File: tb/tb_bsg_clk_mon_multi.sv
// Bench for bsg_clk_mon_multi: table of one-shot measurements plus
// hand-written continuous, start-ignore and reset-abort sequences.
// Expected results are queued at start and checked when done_o fires.

module tb_bsg_clk_mon_multi;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int WW = 20;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          continuous_i;
  logic [WW-1:0] window_i;
  logic [CW-1:0] min_i;
  logic [CW-1:0] max_i;
  logic [N-1:0]  div_clk_i;
  logic          busy_o;
  logic          done_o;
  logic [N*CW-1:0] count_o;
  logic [N-1:0]  in_range_o;
  logic [N-1:0]  overflow_o;

  bsg_clk_mon_multi #(
    .els_p(N), .count_width_p(CW), .window_width_p(WW), .sync_stages_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .continuous_i(continuous_i),
    .window_i(window_i), .min_i(min_i), .max_i(max_i), .div_clk_i(div_clk_i),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
    .in_range_o(in_range_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] lo;
    logic [3:0][7:0] hi;
    logic [3:0]      inr;
    logic [3:0]      ovf;
  } exp_t;

  typedef struct packed {
    logic [19:0]      win;
    logic [7:0]       mn;
    logic [7:0]       mx;
    logic [3:0][15:0] per;
    logic [3:0]       lvl;
    exp_t             e;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Per-channel stimulus clock: period 0 means static at lvl_cur.
  int         per_cur[4] = '{0, 0, 0, 0};
  int         ph[4]      = '{0, 0, 0, 0};
  logic [3:0] lvl_cur    = 4'b0;

  initial begin
    div_clk_i = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (per_cur[i] == 0) begin
          div_clk_i[i] = lvl_cur[i];
        end else begin
          ph[i] = (ph[i] + 1) % per_cur[i];
          div_clk_i[i] = (ph[i] < per_cur[i] / 2);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, logic [31:0] act, logic [31:0] lo, logic [31:0] hi);
    total++;
    if ($isunknown(act) || act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic pop_check(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got done_o=1 required no result pending", tag);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        chk_rng($sformatf("%s_cnt%0d", tag, i), 32'(count_o[i*CW +: CW]), 32'(e.lo[i]), 32'(e.hi[i]));
      end
      chk($sformatf("%s_inr", tag), 32'(in_range_o), 32'(e.inr));
      chk($sformatf("%s_ovf", tag), 32'(overflow_o), 32'(e.ovf));
    end
  endtask

  function automatic vec_t mk(int win, int mn, int mx, int p0, int p1, int p2, int p3,
                              logic [3:0] lvl, int c0, int c1, int c2, int c3, int c2hi,
                              logic [3:0] inr, logic [3:0] ovf);
    vec_t v;
    v.win = 20'(win);
    v.mn  = 8'(mn);
    v.mx  = 8'(mx);
    v.per[0] = 16'(p0); v.per[1] = 16'(p1); v.per[2] = 16'(p2); v.per[3] = 16'(p3);
    v.lvl = lvl;
    v.e.lo[0] = 8'(c0); v.e.lo[1] = 8'(c1); v.e.lo[2] = 8'(c2); v.e.lo[3] = 8'(c3);
    v.e.hi[0] = 8'(c0); v.e.hi[1] = 8'(c1); v.e.hi[2] = 8'(c2hi); v.e.hi[3] = 8'(c3);
    v.e.inr = inr;
    v.e.ovf = ovf;
    return v;
  endfunction

  function automatic exp_t mk_exp(int c0, logic [3:0] inr);
    exp_t e;
    e.lo = '0;
    e.hi = '0;
    e.lo[0] = 8'(c0);
    e.hi[0] = 8'(c0);
    e.inr = inr;
    e.ovf = 4'b0;
    return e;
  endfunction

  task automatic settle(int p0, int p1, int p2, int p3, logic [3:0] lvl);
    per_cur[0] = p0; per_cur[1] = p1; per_cur[2] = p2; per_cur[3] = p3;
    lvl_cur = lvl;
    repeat (12) @(negedge clk);
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic do_start(int win, logic cont, int mn, int mx);
    window_i     = WW'(win);
    continuous_i = cont;
    min_i        = CW'(mn);
    max_i        = CW'(mx);
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_vec(int idx, vec_t v);
    int w, nbusy, ndone, kdone;
    string tag;
    tag = $sformatf("vec%0d", idx);
    settle(int'(v.per[0]), int'(v.per[1]), int'(v.per[2]), int'(v.per[3]), v.lvl);
    sb.push_back(v.e);
    do_start(int'(v.win), 1'b0, int'(v.mn), int'(v.mx));
    w = (v.win == 0) ? 1 : int'(v.win);
    nbusy = 0; ndone = 0; kdone = 0;
    for (int k = 1; k <= w + 20; k++) begin
      @(negedge clk);
      if (busy_o) nbusy++;
      if (done_o) begin
        ndone++;
        kdone = k;
        pop_check(tag);
      end
    end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_latency"}, kdone, w + 1);
    chk({tag, "_busy_cycles"}, nbusy, w);
  endtask

  vec_t vt[8];

  initial begin
    int ndone, nlow, nhigh, k1, k2;

    vt[0] = mk(100,  0, 255, 10, 0, 0, 0, 4'b0000, 10,   0,  0, 0,  0, 4'b1111, 4'b0000);
    vt[1] = mk(1000, 0, 255,  0, 2, 0, 0, 4'b0000,  0, 255,  0, 0,  0, 4'b1101, 4'b0010);
    vt[2] = mk(100,  9,  11, 10, 0, 8, 0, 4'b0000, 10,   0, 12, 0, 13, 4'b0001, 4'b0000);
    vt[3] = mk(100, 20,   5, 10, 0, 8, 0, 4'b0000, 10,   0, 12, 0, 13, 4'b0000, 4'b0000);
    vt[4] = mk(100, 10,  10, 10, 0, 0, 0, 4'b0000, 10,   0,  0, 0,  0, 4'b0001, 4'b0000);
    vt[5] = mk(100,  0,   0, 10, 0, 0, 0, 4'b0000, 10,   0,  0, 0,  0, 4'b1110, 4'b0000);
    vt[6] = mk(0,    0, 255,  0, 0, 0, 0, 4'b1000,  0,   0,  0, 0,  0, 4'b1111, 4'b0000);
    vt[7] = mk(1,    0, 255,  0, 0, 0, 0, 4'b1000,  0,   0,  0, 0,  0, 4'b1111, 4'b0000);

    reset_i = 1'b1; start_i = 1'b0; continuous_i = 1'b0;
    window_i = '0; min_i = '0; max_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_count", count_o, 0);
    chk("rst_inr", 32'(in_range_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    reset_i = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // Continuous: windows of 50, ch0 period 5; continuous dropped mid fifth window.
    settle(5, 0, 0, 0, 4'b0000);
    sb.push_back(mk_exp(10, 4'b1111));
    do_start(50, 1'b1, 0, 255);
    ndone = 0; nlow = 0; nhigh = 0;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      if (k <= 250 && !busy_o) nlow++;
      if (k > 250 && busy_o) nhigh++;
      if (done_o) begin
        ndone++;
        chk("cont_done_pos", (k - 1) % 50, 0);
        pop_check("cont");
        if (continuous_i) sb.push_back(mk_exp(10, 4'b1111));
      end
      if (k == 220) continuous_i = 1'b0;
    end
    chk("cont_ndone", ndone, 5);
    chk("cont_busy_low", nlow, 0);
    chk("cont_busy_after", nhigh, 0);
    chk("cont_sb_empty", sb.size(), 0);

    // start_i during MEASURE is ignored; start in the done cycle is accepted.
    settle(10, 0, 0, 0, 4'b0000);
    sb.push_back(mk_exp(10, 4'b1111));
    do_start(100, 1'b0, 0, 255);
    ndone = 0; k1 = 0; k2 = 0;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k == 10 || k == 50 || k == 150) start_i = 1'b1;
      if (k == 102) chk("hold_count_after_start", 32'(count_o[CW-1:0]), 10);
      if (done_o) begin
        ndone++;
        if (ndone == 1) k1 = k; else k2 = k;
        pop_check("ign");
        if (ndone == 1) begin
          start_i = 1'b1;
          sb.push_back(mk_exp(10, 4'b1111));
        end
      end
    end
    start_i = 1'b0;
    chk("ign_ndone", ndone, 2);
    chk("ign_first_done", k1, 101);
    chk("ign_second_done", k2, 202);

    // Reset at cycle 30 of a 100-cycle window aborts with no done_o.
    settle(10, 0, 0, 0, 4'b0000);
    sb.push_back(mk_exp(10, 4'b1111));
    do_start(100, 1'b0, 0, 255);
    ndone = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      reset_i = 1'b0;
      if (done_o) ndone++;
      if (k == 31) begin
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_count", count_o, 0);
        chk("abort_inr", 32'(in_range_o), 0);
        chk("abort_ovf", 32'(overflow_o), 0);
      end
      if (k == 30) begin
        reset_i = 1'b1;
        sb.delete();
      end
    end
    chk("abort_ndone", ndone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
